// File: rtl/bus_pkg.sv
// Shared datapath bus definitions: default geometry and the bus source map.
package bus_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N_SRC = 24;

  // Bus source indices (bit position in the one-hot *out enable vector)
  localparam int unsigned R0     = 0;
  localparam int unsigned R1     = 1;
  localparam int unsigned R2     = 2;
  localparam int unsigned R3     = 3;
  localparam int unsigned R4     = 4;
  localparam int unsigned R5     = 5;
  localparam int unsigned R6     = 6;
  localparam int unsigned R7     = 7;
  localparam int unsigned R8     = 8;
  localparam int unsigned R9     = 9;
  localparam int unsigned R10    = 10;
  localparam int unsigned R11    = 11;
  localparam int unsigned R12    = 12;
  localparam int unsigned R13    = 13;
  localparam int unsigned R14    = 14;
  localparam int unsigned R15    = 15;
  localparam int unsigned HI     = 16;
  localparam int unsigned LO     = 17;
  localparam int unsigned ZHI    = 18;
  localparam int unsigned ZLO    = 19;
  localparam int unsigned PC     = 20;
  localparam int unsigned MDR    = 21;
  localparam int unsigned INPORT = 22;
  localparam int unsigned C      = 23;

endpackage

// File: rtl/onehot_prio_enc.sv
// Priority encoder for a nominally one-hot request vector: reports the lowest
// set index, whether any bit is set, and whether more than one bit is set.
module onehot_prio_enc #(
  parameter int N     = 24,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  logic found;

  // Lowest set bit wins; idx stays 0 when nothing is requested
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  assign any = |req;

  // Clearing the lowest set bit leaves something only if two or more were set
  assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/bus_mux_reg.sv
// Registered datapath bus multiplexer with priority resolution of
// multiple-driver conflicts and a saturating conflict counter for debug.
module bus_mux_reg
  import bus_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_SRC     = DEF_N_SRC,
  parameter int HOLD_MODE = 1,
  parameter int CNT_W     = 8,
  parameter int SEL_W     = $clog2(N_SRC)
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [N_SRC-1:0]       src_out,
  input  logic                   bus_en,
  input  logic                   conflict_ack,
  output logic [WIDTH-1:0]       bus_out,
  output logic [SEL_W-1:0]       bus_sel,
  output logic                   bus_valid,
  output logic                   conflict,
  output logic                   conflict_sticky,
  output logic [CNT_W-1:0]       conflict_count
);

  logic [SEL_W-1:0] sel_idx;
  logic             src_any;
  logic             src_multi;
  logic [WIDTH-1:0] sel_word;
  logic             transfer;
  logic             conflict_now;

  onehot_prio_enc #(
    .N     (N_SRC),
    .IDX_W (SEL_W)
  ) u_enc (
    .req   (src_out),
    .idx   (sel_idx),
    .any   (src_any),
    .multi (src_multi)
  );

  // Word select; comparing against each legal index keeps the mux in range
  // even when N_SRC is not a power of two
  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (SEL_W'(i) == sel_idx) sel_word = src_data[i*WIDTH +: WIDTH];
    end
  end

  assign transfer     = bus_en & src_any;
  assign conflict_now = transfer & src_multi;

  // Bus data, source index and valid flag
  always_ff @(posedge clock) begin
    if (!clear) begin
      bus_out   <= '0;
      bus_sel   <= '0;
      bus_valid <= 1'b0;
    end else if (transfer) begin
      bus_out   <= sel_word;
      bus_sel   <= sel_idx;
      bus_valid <= 1'b1;
    end else begin
      bus_valid <= 1'b0;
      if (HOLD_MODE == 0) bus_out <= '0;
    end
  end

  // Conflict pulse, sticky flag and saturating counter; a conflict in the
  // same cycle as an ack restarts the count at one
  always_ff @(posedge clock) begin
    if (!clear) begin
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
      conflict_count  <= '0;
    end else begin
      conflict <= conflict_now;
      if (conflict_now) begin
        conflict_sticky <= 1'b1;
        if (conflict_ack)               conflict_count <= CNT_W'(1);
        else if (conflict_count != '1)  conflict_count <= conflict_count + CNT_W'(1);
      end else if (conflict_ack) begin
        conflict_sticky <= 1'b0;
        conflict_count  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_mux_reg.sv
// Bench for bus_mux_reg: a default build (hold mode, 24x32) and a small build
// (zero-on-idle, 5x8, 2-bit counter) checked against a behavioural model.
module tb_bus_mux_reg;
  import bus_pkg::*;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  // Build A: defaults
  logic [24*32-1:0] a_data = '0;
  logic [23:0]      a_src  = '0;
  logic             a_en   = 1'b0;
  logic             a_ack  = 1'b0;
  logic [31:0]      a_bus_out;
  logic [4:0]       a_bus_sel;
  logic             a_valid, a_conf, a_sticky;
  logic [7:0]       a_cnt;

  // Build B: small, zero on idle, narrow counter
  logic [5*8-1:0]   b_data = '0;
  logic [4:0]       b_src  = '0;
  logic             b_en   = 1'b0;
  logic             b_ack  = 1'b0;
  logic [7:0]       b_bus_out;
  logic [2:0]       b_bus_sel;
  logic             b_valid, b_conf, b_sticky;
  logic [1:0]       b_cnt;

  bus_mux_reg dut_a (
    .clock(clock), .clear(clear), .src_data(a_data), .src_out(a_src),
    .bus_en(a_en), .conflict_ack(a_ack), .bus_out(a_bus_out), .bus_sel(a_bus_sel),
    .bus_valid(a_valid), .conflict(a_conf), .conflict_sticky(a_sticky),
    .conflict_count(a_cnt)
  );

  bus_mux_reg #(.WIDTH(8), .N_SRC(5), .HOLD_MODE(0), .CNT_W(2)) dut_b (
    .clock(clock), .clear(clear), .src_data(b_data), .src_out(b_src),
    .bus_en(b_en), .conflict_ack(b_ack), .bus_out(b_bus_out), .bus_sel(b_bus_sel),
    .bus_valid(b_valid), .conflict(b_conf), .conflict_sticky(b_sticky),
    .conflict_count(b_cnt)
  );

  logic [47:0] act_a;
  logic [15:0] act_b;
  assign act_a = {a_bus_out, a_bus_sel, a_valid, a_conf, a_sticky, a_cnt};
  assign act_b = {b_bus_out, b_bus_sel, b_valid, b_conf, b_sticky, b_cnt};

  typedef struct {
    logic [31:0] out;
    int          sel;
    bit          valid;
    bit          conf;
    bit          sticky;
    int          cnt;
  } m_t;

  m_t ma = '{out: '0, sel: 0, valid: 0, conf: 0, sticky: 0, cnt: 0};
  m_t mb = '{out: '0, sel: 0, valid: 0, conf: 0, sticky: 0, cnt: 0};

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model of one clock edge, written from the bus rules
  task automatic model_edge(input int width, input int nsrc, input int cnt_max,
                            input bit hold, input logic rst_n, input logic en,
                            input logic ack, input logic [31:0] src,
                            input logic [767:0] data, inout m_t m);
    logic [31:0] live;
    logic [31:0] mask;
    int lo;
    if (!rst_n) begin
      m.out = '0; m.sel = 0; m.valid = 0; m.conf = 0; m.sticky = 0; m.cnt = 0;
      return;
    end
    live = src & ((32'd1 << nsrc) - 32'd1);
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    lo = -1;
    for (int i = nsrc - 1; i >= 0; i--) if (live[i]) lo = i;
    if (en && lo >= 0) begin
      m.out   = 32'(data >> (lo * width)) & mask;
      m.sel   = lo;
      m.valid = 1;
    end else begin
      m.valid = 0;
      if (!hold) m.out = '0;
    end
    m.conf = en && ($countones(live) > 1);
    if (ack) begin
      m.sticky = 0;
      m.cnt    = 0;
    end
    if (m.conf) begin
      m.sticky = 1;
      if (m.cnt < cnt_max) m.cnt++;
    end
  endtask

  function automatic logic [47:0] exp_a();
    return {ma.out, 5'(ma.sel), 1'(ma.valid), 1'(ma.conf), 1'(ma.sticky), 8'(ma.cnt)};
  endfunction

  function automatic logic [15:0] exp_b();
    return {8'(mb.out), 3'(mb.sel), 1'(mb.valid), 1'(mb.conf), 1'(mb.sticky), 2'(mb.cnt)};
  endfunction

  // One clock edge: advance both models on the sampled inputs, then settle
  task automatic tick();
    @(posedge clock);
    model_edge(32, 24, 255, 1'b1, clear, a_en, a_ack, 32'(a_src), a_data, ma);
    model_edge(8, 5, 3, 1'b0, clear, b_en, b_ack, 32'(b_src), 768'(b_data), mb);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    a_data[PC*32 +: 32] = 32'h0000_0ABC;
    a_src = 24'(1) << PC; a_en = 1'b1; a_ack = 1'b1;
    b_data[2*8 +: 8] = 8'h5C;
    b_src = 5'b00100; b_en = 1'b1; b_ack = 1'b1;
    tick();
    vectors++;
    if (act_a !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_a: got %h expected %h", act_a, 48'h0);
    end
    vectors++;
    if (act_b !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_b: got %h expected %h", act_b, 16'h0);
    end
    clear = 1'b1; a_ack = 1'b0; b_ack = 1'b0;
    tick();
    vectors++;
    if ({a_bus_out, a_bus_sel, a_valid} !== {32'h0000_0ABC, 5'd20, 1'b1}) begin
      miscompares++;
      $display("FAIL release_a: got out=%h sel=%0d valid=%b expected out=00000abc sel=20 valid=1",
               a_bus_out, a_bus_sel, a_valid);
    end
    vectors++;
    if (act_b !== exp_b()) begin
      miscompares++;
      $display("FAIL release_b: got %h expected %h", act_b, exp_b());
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 24; i++) a_data[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
    a_en = 1'b1; b_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a_src = 24'(1) << i;
      b_src = 5'(1) << (i % 5);
      b_data[(i % 5)*8 +: 8] = 8'hA0 + 8'(i);
      tick();
      vectors++;
      if (act_a !== exp_a() || a_conf !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_a i=%0d: got %h expected %h", i, act_a, exp_a());
      end
      vectors++;
      if (act_b !== exp_b()) begin
        miscompares++;
        $display("FAIL sweep_b i=%0d: got %h expected %h", i, act_b, exp_b());
      end
    end
  endtask

  task automatic test_conflict();
    logic [1:0] b_sat [5];
    b_sat[0] = 2'd1; b_sat[1] = 2'd2; b_sat[2] = 2'd3; b_sat[3] = 2'd3; b_sat[4] = 2'd3;
    a_data[R3*32 +: 32]  = 32'h11;
    a_data[MDR*32 +: 32] = 32'h22;
    a_src = (24'(1) << R3) | (24'(1) << MDR);
    b_data[0 +: 8] = 8'h33; b_data[3*8 +: 8] = 8'h44;
    b_src = 5'b01001;
    a_en = 1'b1; b_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (act_a !== exp_a()) begin
        miscompares++;
        $display("FAIL conflict_a cyc=%0d: got %h expected %h", i, act_a, exp_a());
      end
      vectors++;
      if (b_cnt !== b_sat[i] || act_b !== exp_b()) begin
        miscompares++;
        $display("FAIL saturate_b cyc=%0d: got cnt=%0d (%h) expected cnt=%0d (%h)",
                 i, b_cnt, act_b, b_sat[i], exp_b());
      end
      if (i == 3) begin
        vectors++;
        if ({a_bus_out, a_bus_sel, a_conf, a_sticky, a_cnt} !== {32'h11, 5'd3, 1'b1, 1'b1, 8'd4}) begin
          miscompares++;
          $display("FAIL conflict4_a: got out=%h sel=%0d conf=%b sticky=%b cnt=%0d expected 11/3/1/1/4",
                   a_bus_out, a_bus_sel, a_conf, a_sticky, a_cnt);
        end
      end
    end
  endtask

  task automatic test_ack();
    // Count is 5 here; ack alone clears it
    a_en = 1'b0; b_en = 1'b0; a_ack = 1'b1; b_ack = 1'b1;
    tick();
    vectors++;
    if ({a_conf, a_sticky, a_cnt} !== {1'b0, 1'b0, 8'd0} || act_a !== exp_a()) begin
      miscompares++;
      $display("FAIL ack_a: got %h expected %h", act_a, exp_a());
    end
    // Ack with a new conflict in the same cycle
    a_en = 1'b1; b_en = 1'b1;
    tick();
    vectors++;
    if ({a_conf, a_sticky, a_cnt} !== {1'b1, 1'b1, 8'd1} || act_a !== exp_a()) begin
      miscompares++;
      $display("FAIL ack_conflict_a: got %h expected %h", act_a, exp_a());
    end
    vectors++;
    if (act_b !== exp_b()) begin
      miscompares++;
      $display("FAIL ack_conflict_b: got %h expected %h", act_b, exp_b());
    end
    // Several enables without bus_en are not a conflict
    a_ack = 1'b0; b_ack = 1'b0; a_en = 1'b0; b_en = 1'b0;
    a_src = (24'(1) << R0) | (24'(1) << R1); b_src = 5'b00011;
    tick();
    vectors++;
    if ({a_conf, a_cnt} !== {1'b0, 8'd1} || act_a !== exp_a()) begin
      miscompares++;
      $display("FAIL no_en_multi_a: got %h expected %h", act_a, exp_a());
    end
    vectors++;
    if (act_b !== exp_b()) begin
      miscompares++;
      $display("FAIL no_en_multi_b: got %h expected %h", act_b, exp_b());
    end
  endtask

  task automatic test_idle();
    a_data[5*32 +: 32] = 32'hDEAD_BEEF; a_src = 24'(1) << 5; a_en = 1'b1;
    b_data[1*8 +: 8]   = 8'hEF;         b_src = 5'b00010;    b_en = 1'b1;
    tick();
    vectors++;
    if (act_a !== exp_a()) begin
      miscompares++;
      $display("FAIL idle_load_a: got %h expected %h", act_a, exp_a());
    end
    a_en = 1'b0; b_en = 1'b0;
    tick();
    vectors++;
    if ({a_bus_out, a_valid} !== {32'hDEAD_BEEF, 1'b0} || act_a !== exp_a()) begin
      miscompares++;
      $display("FAIL idle_hold_a: got %h expected %h", act_a, exp_a());
    end
    vectors++;
    if ({b_bus_out, b_valid} !== {8'h00, 1'b0} || act_b !== exp_b()) begin
      miscompares++;
      $display("FAIL idle_zero_b: got %h expected %h", act_b, exp_b());
    end
    // bus_en with no enables is idle, not a conflict
    b_en = 1'b1; b_src = 5'b00010;
    tick();
    a_en = 1'b1; a_src = '0; b_src = '0;
    tick();
    vectors++;
    if (act_a !== exp_a()) begin
      miscompares++;
      $display("FAIL idle_noenable_a: got %h expected %h", act_a, exp_a());
    end
    vectors++;
    if (act_b !== exp_b()) begin
      miscompares++;
      $display("FAIL idle_noenable_b: got %h expected %h", act_b, exp_b());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 24; i++) a_data[i*32 +: 32] = $urandom;
      b_data = {8'($urandom), 32'($urandom)};
      case ($urandom_range(0, 3))
        0:       a_src = '0;
        1:       a_src = 24'(1) << $urandom_range(0, 23);
        2:       a_src = (24'(1) << $urandom_range(0, 23)) | (24'(1) << $urandom_range(0, 23));
        default: a_src = 24'($urandom);
      endcase
      b_src = ($urandom_range(0, 1) == 0) ? (5'(1) << $urandom_range(0, 4)) : 5'($urandom);
      a_en  = ($urandom_range(0, 3) != 0);
      b_en  = ($urandom_range(0, 3) != 0);
      a_ack = ($urandom_range(0, 7) == 0);
      b_ack = ($urandom_range(0, 7) == 0);
      clear = ($urandom_range(0, 31) != 0);
      tick();
      vectors++;
      if (act_a !== exp_a()) begin
        miscompares++;
        $display("FAIL random_a n=%0d: got %h expected %h", n, act_a, exp_a());
      end
      vectors++;
      if (act_b !== exp_b()) begin
        miscompares++;
        $display("FAIL random_b n=%0d: got %h expected %h", n, act_b, exp_b());
      end
    end
    clear = 1'b1;
  endtask

  initial begin
    #2;
    test_reset();
    test_sweep();
    test_conflict();
    test_ack();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_mux_reg.md
# bus_mux_reg

Parametrised, registered successor to the datapath bus multiplexer. It selects one of `N_SRC` source words onto the shared datapath bus using the one-hot `*out` enables from the control unit, and registers the result. It detects multiple-driver conflicts, resolves them by priority, and counts them for debug. It sits between the register file, the special registers (HI, LO, Z, PC, MDR, In.Port, C) and every bus consumer.

## Interface
Parameters:
- `WIDTH`, 32: bus word width.
- `N_SRC`, 24: number of bus sources, at least 2.
- `HOLD_MODE`, 1: 1 = bus holds its last value when idle; 0 = bus forced to zero when idle.
- `CNT_W`, 8: width of the conflict counter.
- `SEL_W`, $clog2(N_SRC): derived; not to be overridden.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  synchronous, active-low reset.
- `src_data`  in  N_SRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- `src_out`  in  N_SRC  one-hot source enables; bit i = source i drives.
- `bus_en`  in  1  bus transfer requested this cycle.
- `conflict_ack`  in  1  clears `conflict_sticky` and `conflict_count`.
- `bus_out`  out  WIDTH  registered bus value.
- `bus_sel`  out  SEL_W  index of the source captured into `bus_out`.
- `bus_valid`  out  1  `bus_out` holds a freshly driven word.
- `conflict`  out  1  one-cycle pulse: more than one `src_out` bit was set during a transfer.
- `conflict_sticky`  out  1  latched conflict flag.
- `conflict_count`  out  CNT_W  saturating count of conflict cycles.

## Operation
- **Transfer condition:** a transfer occurs when `bus_en`=1 and `src_out`≠0.
- **Selected source:** the lowest set index of `src_out` (priority encode).
  - `bus_out` ← word at that index.
  - `bus_sel` ← that index.
  - `bus_valid` ← 1.
- **Idle:** `bus_en`=0, or `bus_en`=1 with `src_out`=0.
  - `bus_valid` ← 0.
  - `bus_sel` holds.
  - `HOLD_MODE`=1: `bus_out` holds.
  - `HOLD_MODE`=0: `bus_out` ← 0.
- **Conflict:** a transfer with popcount(`src_out`) > 1.
  - The transfer still completes using the lowest index.
  - `conflict` ← 1 for one cycle.
  - `conflict_sticky` ← 1.
  - `conflict_count` increments, saturating at 2^CNT_W−1.
- **Enables without `bus_en`:** multiple `src_out` bits with `bus_en`=0 are not a conflict.
- **`conflict_ack`:**
  - `conflict_sticky` ← 0 and `conflict_count` ← 0.
  - If the same cycle also has a conflict, the result is sticky=1, count=1 (the new event wins over the clear).
  - `conflict_ack` does not affect `conflict`, `bus_out`, `bus_sel` or `bus_valid`.
- **Source indices ≥ N_SRC:** cannot occur. `bus_sel` is never driven outside 0..N_SRC−1.

## Timing
- **Latency:** 1 cycle. Inputs sampled at edge k appear on outputs after edge k.
- **Per-cycle behaviour:** no back-pressure and no handshake; every cycle is independent.
- **Reset (`clear`=0 at an edge):**
  - `bus_out`=0, `bus_sel`=0, `bus_valid`=0.
  - `conflict`=0, `conflict_sticky`=0, `conflict_count`=0.
  - Reset overrides any simultaneous transfer or ack.
  - Reset asserted mid-stream discards the in-flight word; the first transfer after `clear` returns to 1 is visible one edge later.
- **Back-to-back transfers:** supported every cycle, including consecutive conflicts (the counter increments each cycle).
- **Combinational paths:** none from inputs to outputs.

## Structure
- **Shared package `bus_pkg`:**
  - Source index constants: R0..R15 = 0..15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, C=23.
  - Default `WIDTH` and `N_SRC`.
- **Sub-module `onehot_prio_enc`:** combinational and parametrised by `N`. Outputs:
  - `idx`: lowest set bit.
  - `any`: OR of inputs.
  - `multi`: more than one bit set.
- **Top level contains:** the encoder, the indexed word select, and the output/conflict registers.

## Test plan
- **Reset:** drive `clear`=0 with `bus_en`=1, `src_out`=1<<PC, PC=0x0000_0ABC → after the edge all outputs are 0. Release `clear` → next edge `bus_out`=0x0000_0ABC, `bus_sel`=20, `bus_valid`=1.
- **Sweep:** source i = 0xA5A5_0000+i, one-hot each i over 0..23 on consecutive cycles → `bus_out`/`bus_sel` match i one cycle later, `conflict` stays 0.
- **Conflict:** `src_out` = R3|MDR, R3=0x11, MDR=0x22 → `bus_out`=0x11, `bus_sel`=3, `conflict` pulses 1 for one cycle, sticky=1, count=1. Repeat 3 more cycles → count=4.
- **Idle modes:**
  - `HOLD_MODE`=1: after a transfer of 0xDEAD_BEEF, `bus_en`=0 → `bus_out` stays 0xDEAD_BEEF, `bus_valid`=0.
  - `HOLD_MODE`=0: same stimulus → `bus_out`=0.
  - Either mode: `bus_en`=1 with `src_out`=0 → idle behaviour, no conflict.
- **Ack:**
  - count=5, `conflict_ack` alone → sticky=0, count=0.
  - `conflict_ack` plus a conflict in the same cycle → sticky=1, count=1.
  - `src_out` = R0|R1 with `bus_en`=0 → no conflict recorded.
- **Saturation:** `CNT_W`=2, 5 consecutive conflicts → count 1, 2, 3, 3, 3; `N_SRC`=5, `WIDTH`=8 build passes the sweep test.
